// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Byte 0 of a block is bits [127:120]; bytes run down the columns (column-major).
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    F_ISSUE = 3'd3,
    F_WAIT  = 3'd4,
    DONE    = 3'd5
  } fsm_t;

  localparam int NUM_ROUNDS    = 10;
  localparam int LAST_MC_ROUND = 9;
  localparam int STATE_BYTES   = 16;

  // Bit offset of the LSB of byte idx within a 128-bit block.
  function automatic int byte_lsb(input int idx);
    return 8 * (STATE_BYTES - 1 - idx);
  endfunction

endpackage

// File: rtl/aes_shift_rows.sv
// Combinational AES ShiftRows on a column-major 128-bit block; zero latency.
// Row r of the block is rotated left by r byte positions.
module aes_shift_rows
  import aes_pkg::*;
(
  input  logic [127:0] state,
  output logic [127:0] shifted
);

  for (genvar i = 0; i < STATE_BYTES; i++) begin : g_byte
    assign shifted[byte_lsb(i) +: 8] =
      state[byte_lsb((i + 4 * (i % 4)) % STATE_BYTES) +: 8];
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns the working state, issues rounds to external units, adds round keys.
// Latency 9(L+1)+LF+2 cycles from accept to out_valid; output held until out_ready, one block in flight.
module aes_round_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [3:0]            key_idx,
  input  logic [DATA_WIDTH-1:0] round_key,
  output logic                  dp_valid_o,
  output logic [DATA_WIDTH-1:0] dp_state_o,
  input  logic                  dp_valid_i,
  input  logic [DATA_WIDTH-1:0] dp_state_i,
  output logic                  fr_valid_o,
  output logic [DATA_WIDTH-1:0] fr_state_o,
  input  logic                  fr_valid_i,
  input  logic [DATA_WIDTH-1:0] fr_state_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            round_o,
  output logic                  err_o
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
  localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

  fsm_t                  fsm_q;
  logic [DATA_WIDTH-1:0] state_q;
  logic [DATA_WIDTH-1:0] shifted;
  logic [3:0]            round_q;
  logic [7:0]            wait_q;
  logic                  accept;
  logic                  dp_timeout;
  logic                  fr_timeout;
  logic                  stray;

  aes_shift_rows u_shift_rows (
    .state   (state_q),
    .shifted (shifted)
  );

  assign in_ready   = (fsm_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign dp_valid_o = (fsm_q == ISSUE) && !rst;
  assign fr_valid_o = (fsm_q == F_ISSUE) && !rst;
  assign dp_state_o = shifted;
  assign fr_state_o = shifted;
  assign out_valid  = (fsm_q == DONE) && !rst;
  assign out_data   = state_q;
  // round_q is 0 in IDLE and 10 after round 9, so it doubles as the key index.
  assign key_idx    = rst ? 4'd0 : round_q;
  assign round_o    = rst ? 4'd0 : round_q;

  // A response arriving on the timeout cycle wins over the timeout.
  assign dp_timeout = (fsm_q == WAIT)   && !dp_valid_i && (wait_q == TO_CNT);
  assign fr_timeout = (fsm_q == F_WAIT) && !fr_valid_i && (wait_q == TO_CNT);
  assign stray      = (dp_valid_i && (fsm_q != WAIT)) || (fr_valid_i && (fsm_q != F_WAIT));
  assign err_o      = !rst && (dp_timeout || fr_timeout || stray);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
      wait_q  <= 8'd0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_q <= in_data ^ round_key;
            round_q <= 4'd1;
            fsm_q   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_q <= 8'd0;
          fsm_q  <= WAIT;
        end
        WAIT: begin
          if (dp_valid_i) begin
            state_q <= dp_state_i ^ round_key;
            round_q <= round_q + 4'd1;
            fsm_q   <= (round_q == LAST_RND) ? F_ISSUE : ISSUE;
          end else if (dp_timeout) begin
            state_q <= '0;
            round_q <= 4'd0;
            wait_q  <= 8'd0;
            fsm_q   <= IDLE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        F_ISSUE: begin
          wait_q <= 8'd0;
          fsm_q  <= F_WAIT;
        end
        F_WAIT: begin
          if (fr_valid_i) begin
            state_q <= fr_state_i ^ round_key;
            fsm_q   <= DONE;
          end else if (fr_timeout) begin
            state_q <= '0;
            round_q <= 4'd0;
            wait_q  <= 8'd0;
            fsm_q   <= IDLE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            round_q <= 4'd0;
            fsm_q   <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with behavioural datapath, final-round unit and key store.
// Expected ciphertexts come from known-answer vectors and a full AES-128 reference function.
module tb_aes_round_ctrl;

  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         dp_valid_o;
  logic [127:0] dp_state_o;
  logic         dp_valid_i;
  logic [127:0] dp_state_i;
  logic         fr_valid_o;
  logic [127:0] fr_state_o;
  logic         fr_valid_i;
  logic [127:0] fr_state_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   round_o;
  logic         err_o;

  always #5 clk = ~clk;

  aes_round_ctrl #(.DATA_WIDTH(128), .NUM_ROUNDS(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .round_key(round_key),
    .dp_valid_o(dp_valid_o), .dp_state_o(dp_state_o), .dp_valid_i(dp_valid_i), .dp_state_i(dp_state_i),
    .fr_valid_o(fr_valid_o), .fr_state_o(fr_state_o), .fr_valid_i(fr_valid_i), .fr_state_i(fr_state_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .round_o(round_o), .err_o(err_o)
  );

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rkeys [16];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[127 - 8 * (4 * c + r) -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = sbox[s[127 - 8 * i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_ref(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127 - 8 * (4 * c + r) -: 8] = gb(s, r, (c + r) % 4);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = gmul(8'h02, gb(s, r, c)) ^ gmul(8'h03, gb(s, (r + 1) % 4, c))
                                        ^ gb(s, (r + 2) % 4, c) ^ gb(s, (r + 3) % 4, c);
    return o;
  endfunction

  function automatic logic [127:0] round_key_of(input logic [127:0] key, input int rn);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    return {w[4 * rn], w[4 * rn + 1], w[4 * rn + 2], w[4 * rn + 3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ round_key_of(key, 0);
    for (int r = 1; r <= 10; r++) begin
      s = shift_ref(sub_bytes(s));
      if (r < 10) s = mix_cols(s);
      s = s ^ round_key_of(key, r);
    end
    return s;
  endfunction

  assign round_key = rkeys[key_idx];

  // ---------------- behavioural units ----------------
  int dp_rand_lat = 0;
  int drop_round  = 0;
  int stray_req   = 0;
  int stray_ack   = 0;

  initial begin
    logic [127:0] res;
    int lat;
    dp_valid_i = 1'b0;
    dp_state_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && dp_valid_o) begin
        res = mix_cols(sub_bytes(dp_state_o));
        lat = (dp_rand_lat != 0) ? int'($urandom_range(8, 1)) : 2;
        if (int'(round_o) != drop_round) begin
          repeat (lat) @(posedge clk);
          #1 dp_valid_i = 1'b1; dp_state_i = res;
          @(posedge clk);
          #1 dp_valid_i = 1'b0;
        end
      end else if (!rst && out_valid && stray_req > stray_ack) begin
        @(posedge clk);
        #1 dp_valid_i = 1'b1; dp_state_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        #1 dp_valid_i = 1'b0;
        stray_ack = stray_ack + 1;
      end
    end
  end

  initial begin
    logic [127:0] res;
    fr_valid_i = 1'b0;
    fr_state_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && fr_valid_o) begin
        res = sub_bytes(fr_state_o);
        @(posedge clk);
        #1 fr_valid_i = 1'b1; fr_state_i = res;
        @(posedge clk);
        #1 fr_valid_i = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  int   cyc = 0;
  int   dp_cnt = 0, fr_cnt = 0, err_cnt = 0, err_cyc = 0, ov_rise_cnt = 0, hs_cnt = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_ov <= out_valid;
    if (dp_valid_o) dp_cnt <= dp_cnt + 1;
    if (fr_valid_o) fr_cnt <= fr_cnt + 1;
    if (err_o) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (out_valid && !prev_ov) ov_rise_cnt <= ov_rise_cnt + 1;
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_block(input logic [127:0] key, input logic [127:0] pt, output int t0, output bit ok);
    @(posedge clk);
    #1;
    for (int r = 0; r < 16; r++) rkeys[r] = (r <= 10) ? round_key_of(key, r) : '0;
    in_data  = pt;
    in_valid = 1'b1;
    ok = 1'b0;
    t0 = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        t0 = cyc;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit found);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
  endtask

  task automatic run_and_check(input string name, input logic [127:0] key, input logic [127:0] pt,
                               input logic [127:0] exp, input bit chk_lat);
    int t0, dpb, frb, erb;
    bit ok, found;
    out_ready = 1'b1;
    send_block(key, pt, t0, ok);
    check_int({name, "_accept"}, int'(ok), 1);
    dpb = dp_cnt; frb = fr_cnt; erb = err_cnt;
    wait_out(found);
    check_int({name, "_out_seen"}, int'(found), 1);
    check_vec({name, "_ct"}, out_data, exp);
    check_int({name, "_round_done"}, int'(round_o), 10);
    if (chk_lat) check_int({name, "_latency"}, cyc - t0, 30);
    check_int({name, "_dp_pulses"}, dp_cnt - dpb, 9);
    check_int({name, "_fr_pulses"}, fr_cnt - frb, 1);
    check_int({name, "_err_pulses"}, err_cnt - erb, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_int({name, "_ready_after"}, int'(in_ready), 1);
    check_int({name, "_out_dropped"}, int'(out_valid), 0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // ---------------- main sequence ----------------
  initial begin
    vec_t         vecs [3];
    int           t0, erb, orb, hsb;
    bit           ok, found, stable;
    logic [127:0] key, pt;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int r = 0; r < 16; r++) rkeys[r] = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_in_ready", int'(in_ready), 0);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_dp_valid", int'(dp_valid_o), 0);
    check_int("rst_fr_valid", int'(fr_valid_o), 0);
    check_int("rst_err", int'(err_o), 0);
    check_int("rst_round", int'(round_o), 0);
    check_int("rst_key_idx", int'(key_idx), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("post_rst_in_ready", int'(in_ready), 1);

    // known-answer table, issued back to back in order
    vecs[0] = '{key: FIPS_KEY, pt: FIPS_PT, ct: FIPS_CT};
    vecs[1] = '{key: 128'h0, pt: 128'h0, ct: ZERO_CT};
    vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 0; i < 3; i++) run_and_check($sformatf("kat%0d", i), vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b1);

    // backpressure: hold out_ready low for 20 cycles in DONE
    out_ready = 1'b0;
    send_block(FIPS_KEY, FIPS_PT, t0, ok);
    check_int("bp_accept", int'(ok), 1);
    wait_out(found);
    check_int("bp_out_seen", int'(found), 1);
    hsb = hs_cnt;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!out_valid || out_data !== FIPS_CT || in_ready) stable = 1'b0;
    end
    check_int("bp_hold_stable", int'(stable), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check_vec("bp_ct", out_data, FIPS_CT);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_int("bp_ready_after", int'(in_ready), 1);
    check_int("bp_one_delivery", hs_cnt - hsb, 1);

    // timeout: round 4 response dropped
    drop_round = 4;
    send_block(FIPS_KEY, FIPS_PT, t0, ok);
    check_int("to_accept", int'(ok), 1);
    erb = err_cnt; orb = ov_rise_cnt;
    repeat (40) @(negedge clk);
    check_int("to_err_pulses", err_cnt - erb, 1);
    check_int("to_err_cycle", err_cyc - t0, 1 + 3 * 3 + 1 + TIMEOUT);
    check_int("to_no_output", ov_rise_cnt - orb, 0);
    check_int("to_idle", int'(in_ready), 1);
    check_int("to_round_zero", int'(round_o), 0);
    drop_round = 0;
    run_and_check("after_to", FIPS_KEY, FIPS_PT, FIPS_CT, 1'b1);

    // reset during round 5
    send_block(FIPS_KEY, FIPS_PT, t0, ok);
    check_int("mr_accept", int'(ok), 1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (round_o == 4'd5) found = 1'b1;
    end
    check_int("mr_reached_round5", int'(found), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_int("mr_rst_in_ready", int'(in_ready), 0);
    check_int("mr_rst_key_idx", int'(key_idx), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("mr_in_ready", int'(in_ready), 1);
    check_int("mr_out_valid", int'(out_valid), 0);
    check_int("mr_round", int'(round_o), 0);
    repeat (6) @(negedge clk);
    run_and_check("after_mr", 128'h0, 128'h0, ZERO_CT, 1'b1);

    // variable latency plus a stray response while holding DONE
    dp_rand_lat = 1;
    out_ready = 1'b0;
    erb = err_cnt;
    send_block(FIPS_KEY, FIPS_PT, t0, ok);
    check_int("vl_accept", int'(ok), 1);
    wait_out(found);
    check_int("vl_out_seen", int'(found), 1);
    stray_req = stray_req + 1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (stray_ack == stray_req) ok = 1'b1;
    end
    check_int("vl_stray_sent", int'(ok), 1);
    @(negedge clk);
    check_vec("vl_ct", out_data, FIPS_CT);
    check_int("vl_still_valid", int'(out_valid), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_int("vl_ready_after", int'(in_ready), 1);
    check_int("vl_err_pulses", err_cnt - erb, 1);

    // random keys and plaintexts with random datapath latency
    for (int i = 0; i < 6; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_and_check($sformatf("rnd%0d", i), key, pt, aes_encrypt(key, pt), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Round sequencer for AES-128 encryption. It owns the 128-bit working state and accepts one plaintext block at a time. It drives the combined SubByte/MixColumn datapath for rounds 1-9 and a SubBytes-only unit for round 10, applying ShiftRows and AddRoundKey itself. It sits between the block input interface and the round-key store, and returns one ciphertext block per plaintext block through a valid/ready output.

Parameters:
DATA_WIDTH, 128, state/key width; only 128 is supported.
NUM_ROUNDS, 10, total AES rounds (AES-128).
TIMEOUT, 16, maximum cycles to wait for a datapath response before aborting; range 1..255.

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  plaintext valid
in_ready  out  1  controller can accept a block
in_data  in  128  plaintext; byte 0 = [127:120], column-major
key_idx  out  4  round-key index to the key store
round_key  in  128  key for key_idx, combinational, same cycle
dp_valid_o  out  1  issue strobe to the SubByte/MixColumn datapath
dp_state_o  out  128  ShiftRows(state) to the datapath
dp_valid_i  in  1  datapath result valid
dp_state_i  in  128  datapath result
fr_valid_o  out  1  issue strobe to the final-round SubBytes unit
fr_state_o  out  128  ShiftRows(state) to the SubBytes unit
fr_valid_i  in  1  SubBytes result valid
fr_state_i  in  128  SubBytes result
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts
out_data  out  128  ciphertext
round_o  out  4  current round number (debug)
err_o  out  1  one-cycle error pulse

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, F_ISSUE, F_WAIT, DONE. Reset state is IDLE.
- Reset values, for any cycle with rst=1: state_q=0, round=0, key_idx=0, wait counter=0, err_o=0, out_valid=0, dp_valid_o=0, fr_valid_o=0, in_ready=0.
- Reset asserted mid-operation abandons the block; no output is produced for it.
- in_ready = (FSM==IDLE) & !rst. key_idx=0 in IDLE.
- IDLE: on in_valid & in_ready, state_q <= in_data ^ round_key (key 0), round <= 1, go to ISSUE.
- ISSUE (one cycle):
  - dp_valid_o=1 and dp_state_o=ShiftRows(state_q).
  - Clear the wait counter, go to WAIT.
  - dp_valid_o is high only in ISSUE.
- WAIT:
  - key_idx=round.
  - On dp_valid_i: state_q <= dp_state_i ^ round_key and round++.
  - If the completed round was 9 (NUM_ROUNDS-1), go to F_ISSUE; otherwise go to ISSUE.
- F_ISSUE: fr_valid_o=1 and fr_state_o=ShiftRows(state_q), go to F_WAIT.
- F_WAIT:
  - key_idx=10.
  - On fr_valid_i: state_q <= fr_state_i ^ round_key, go to DONE.
- DONE:
  - out_valid=1, out_data=state_q.
  - Hold both stable until out_ready; on out_valid & out_ready, go to IDLE.
  - The next block can be accepted the cycle after the handshake; the controller has no bypass.
- ShiftRows: output byte i = input byte (i + 4*(i mod 4)) mod 16, where byte 0 = [127:120].
- Latency: accept edge at cycle 0; datapath latency L, final-unit latency LF.
  - Round r is issued at cycle 1+(r-1)(L+1).
  - out_valid first rises at cycle 9(L+1)+LF+2; this is 30 for L=2, LF=1.
  - Responses are waited for, never assumed, so any L works.
- Timeout: in WAIT or F_WAIT the counter increments each cycle without a response. When it reaches TIMEOUT:
  - err_o pulses for one cycle and the FSM goes to IDLE.
  - The block is dropped and state_q is cleared.
- Stray response: dp_valid_i outside WAIT, or fr_valid_i outside F_WAIT, is ignored, and err_o pulses for one cycle.
- Simultaneous response and timeout in the same cycle: the response wins and no error is raised.
- round_o = round; it is 0 in IDLE and 10 in DONE.

Decomposition:
- Package aes_pkg holds:
  - the FSM state enum;
  - constants NUM_ROUNDS=10, LAST_MC_ROUND=9, STATE_BYTES=16;
  - byte-index helper for the column-major byte order.
- One combinational sub-module, aes_shift_rows (128 in, 128 out), instantiated once. Its output feeds both dp_state_o and fr_state_o.

Test Plan:
- FIPS-197 C.1, with behavioural datapath (L=2), SubBytes unit (LF=1) and key store. Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rising at cycle 30, exactly 9 dp_valid_o pulses and 1 fr_valid_o pulse.
- Backpressure: out_ready held 0 for 20 cycles after DONE -> out_data and out_valid stable throughout, in_ready=0; one block is delivered when out_ready=1, and in_ready=1 the next cycle.
- Back-to-back: two blocks (FIPS vector, then pt all-zero with key all-zero) -> outputs 69c4e0d8..., then 66e94bd4ef8a2c3b884cfa59ca342b2e, in order.
- Timeout: the datapath drops its response in round 4 -> err_o pulses at cycle TIMEOUT into WAIT, FSM returns to IDLE, and no out_valid is produced; a following block encrypts correctly.
- Reset mid-round: rst=1 for one cycle during round 5 -> the next cycle shows in_ready=1, out_valid=0 and round_o=0; a subsequent block produces correct ciphertext.
- Variable latency: datapath L randomised 1..8 per round, and a stray dp_valid_i injected in DONE -> ciphertext still 69c4e0d8...; err_o pulses exactly once, for the stray response.
